// File: rtl/rom_rr_arbiter_pkg.sv
// Shared types for the ROM round-robin arbiter: FSM states, in-flight tag
// layout and the rotate-and-pick priority helper.
package rom_arb_pkg;

    localparam int MAX_NREQ = 8;
    localparam int ID_W     = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    // Searches upward from ptr and wraps at n, so the pointer position itself has top priority.
    function automatic logic [MAX_NREQ-1:0] rotPick(
        input logic [MAX_NREQ-1:0] req,
        input logic [ID_W-1:0]     ptr,
        input int unsigned         n
    );
        logic [MAX_NREQ-1:0] pick;
        logic [ID_W-1:0]     sel;
        int unsigned         idx;
        pick = '0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            idx = (32'(ptr) + k) % n;
            sel = ID_W'(idx);
            if ((k < n) && (pick == '0) && req[sel]) begin
                pick[sel] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rom_rr_arbiter_if.sv
// Client/ROM-side bus of the arbiter. The slave modport is the arbiter; the
// master modport is whoever plays the requesters and the ROM.
interface rom_rr_arbiter_if #(
    parameter int AW   = 4,
    parameter int DW   = 16,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    gnt;
    logic               halt;
    logic               halted;
    logic               rom_en;
    logic [AW-1:0]      rom_addr;
    logic [DW-1:0]      rom_dout;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;

    modport slave (
        input  req, req_addr, halt, rom_dout,
        output gnt, halted, rom_en, rom_addr, rsp_valid, rsp_data
    );

    modport master (
        output req, req_addr, halt, rom_dout,
        input  gnt, halted, rom_en, rom_addr, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rom_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot winner plus its binary index.
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);

    always_comb begin
        gnt_o = NREQ'(rotPick(MAX_NREQ'(req_i), ID_W'(ptr_i), NREQ));
        idx_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_o[i]) begin
                idx_o = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/rom_rr_arbiter.sv
// Shares one synchronous ROM among NREQ requesters with round-robin grants,
// a tag pipeline that routes read data back, and a halt/drain FSM.
module rom_rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int AW      = 4,
    parameter int DW      = 16,
    parameter int NREQ    = 4,
    parameter int ROM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    rom_rr_arbiter_if.slave bus
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    tag_t            pipe_q [ROM_LAT];
    tag_t            pipe_d [ROM_LAT];

    logic [NREQ-1:0] pickGnt;
    logic [IDW-1:0]  pickIdx;
    logic [NREQ-1:0] gnt;
    logic            grantEn;
    logic            xfer;
    logic            pipeEmpty;
    tag_t            lastTag;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (pickGnt),
        .idx_o (pickIdx)
    );

    // Grants are suppressed while reset is held and in the very cycle halt is first seen.
    always_comb begin
        grantEn      = (state_q == RUN) && !bus.halt && !rst;
        gnt          = grantEn ? pickGnt : '0;
        xfer         = |gnt;
        bus.gnt      = gnt;
        bus.rom_en   = xfer;
        bus.rom_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                bus.rom_addr = bus.req_addr[i*AW +: AW];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (pickIdx == IDW'(NREQ - 1)) ? '0 : pickIdx + 1'b1;
        end
        pipe_d[0] = '{vld: xfer, id: ID_W'(pickIdx)};
        for (int s = 1; s < ROM_LAT; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
        pipeEmpty = 1'b1;
        for (int s = 0; s < ROM_LAT; s++) begin
            if (pipe_q[s].vld) begin
                pipeEmpty = 1'b0;
            end
        end
    end

    // The last tag stage lines up with the cycle the ROM word appears on rom_dout.
    always_comb begin
        lastTag       = pipe_q[ROM_LAT-1];
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        if (lastTag.vld) begin
            bus.rsp_valid = NREQ'(1) << lastTag.id;
            bus.rsp_data  = bus.rom_dout;
        end
    end

    always_comb begin
        state_d    = state_q;
        bus.halted = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.halt) state_d = DRAIN;
            end
            DRAIN: begin
                if (!bus.halt)     state_d = RUN;
                else if (pipeEmpty) state_d = HALTED;
            end
            HALTED: begin
                bus.halted = 1'b1;
                if (!bus.halt) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            ptr_q   <= '0;
            for (int s = 0; s < ROM_LAT; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            for (int s = 0; s < ROM_LAT; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
        end
    end

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Directed bench for rom_rr_arbiter: a ROM_LAT=1 instance for arbitration, halt
// and reset steps, plus a ROM_LAT=3 instance for a back-to-back read burst.
module tb_rom_rr_arbiter;

    typedef struct {
        logic [3:0]  vld;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [15:0] curAddrs;
    logic [3:0]  mV1, mV3;
    logic [15:0] mD1, mD3;
    logic [15:0] r3a, r3b;

    rom_rr_arbiter_if #(.AW(4), .DW(16), .NREQ(4)) bus1 ();
    rom_rr_arbiter_if #(.AW(4), .DW(16), .NREQ(4)) bus3 ();

    rom_rr_arbiter #(.AW(4), .DW(16), .NREQ(4), .ROM_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    rom_rr_arbiter #(.AW(4), .DW(16), .NREQ(4), .ROM_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] romWord(input logic [3:0] a);
        return {a, ~a, a + 4'd3, 4'h6};
    endfunction

    // ROM stand-ins: one registered stage, and a three-stage pipeline.
    always @(posedge clk) begin
        if (bus1.rom_en) bus1.rom_dout <= romWord(bus1.rom_addr);
        r3a           <= romWord(bus3.rom_addr);
        r3b           <= r3a;
        bus3.rom_dout <= r3b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // Responses are popped in the cycle they are due; any other cycle must be silent.
    always @(negedge clk) begin
        mV1 = '0;
        mD1 = '0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            mV1 = q1[0].vld;
            mD1 = q1[0].data;
            void'(q1.pop_front());
        end
        chk("rsp1_valid", 32'(bus1.rsp_valid), 32'(mV1));
        chk("rsp1_data", 32'(bus1.rsp_data), 32'(mD1));
        mV3 = '0;
        mD3 = '0;
        if (q3.size() > 0 && q3[0].due == cyc) begin
            mV3 = q3[0].vld;
            mD3 = q3[0].data;
            void'(q3.pop_front());
        end
        chk("rsp3_valid", 32'(bus3.rsp_valid), 32'(mV3));
        chk("rsp3_data", 32'(bus3.rsp_data), 32'(mD3));
    end

    task automatic applyStimulus(input logic [3:0] req, input logic [15:0] addrs, input logic halt);
        bus1.req      = req;
        bus1.req_addr = addrs;
        bus1.halt     = halt;
        curAddrs      = addrs;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expGnt, input logic expHalted);
        logic [3:0] expAddr;
        @(negedge clk);
        expAddr = '0;
        for (int i = 0; i < 4; i++) begin
            if (expGnt[i]) expAddr = curAddrs[i*4 +: 4];
        end
        chk({tag, "_gnt"}, 32'(bus1.gnt), 32'(expGnt));
        chk({tag, "_rom_en"}, 32'(bus1.rom_en), 32'(|expGnt));
        chk({tag, "_rom_addr"}, 32'(bus1.rom_addr), 32'(expAddr));
        chk({tag, "_halted"}, 32'(bus1.halted), 32'(expHalted));
        if (expGnt != 4'b0000) begin
            q1.push_back('{vld: expGnt, data: romWord(expAddr), due: cyc + 1});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus1.req = '0; bus1.req_addr = '0; bus1.halt = 1'b0; bus1.rom_dout = '0;
        bus3.req = '0; bus3.req_addr = '0; bus3.halt = 1'b0; bus3.rom_dout = '0;
        r3a = '0; r3b = '0; curAddrs = '0;

        checkOutput("reset", 4'b0000, 1'b0);
        rst = 1'b0;

        applyStimulus(4'b0100, 16'h0900, 1'b0);
        checkOutput("single", 4'b0100, 1'b0);
        applyStimulus(4'b0000, 16'h0000, 1'b0);
        checkOutput("single_idle", 4'b0000, 1'b0);

        applyStimulus(4'b1000, 16'h5000, 1'b0);
        checkOutput("ptr_to0", 4'b1000, 1'b0);
        applyStimulus(4'b1111, 16'h4321, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("rotate", 4'b0001 << (k % 4), 1'b0);
        end

        applyStimulus(4'b0010, 16'hDCBA, 1'b0);
        checkOutput("fair_setup", 4'b0010, 1'b0);
        applyStimulus(4'b1011, 16'hDCBA, 1'b0);
        checkOutput("fair_a", 4'b1000, 1'b0);
        checkOutput("fair_b", 4'b0001, 1'b0);
        checkOutput("fair_c", 4'b0010, 1'b0);

        applyStimulus(4'b1111, 16'h8765, 1'b0);
        checkOutput("pre_halt_a", 4'b0100, 1'b0);
        checkOutput("pre_halt_b", 4'b1000, 1'b0);
        applyStimulus(4'b1111, 16'h8765, 1'b1);
        checkOutput("halt_seen", 4'b0000, 1'b0);
        checkOutput("halt_drain", 4'b0000, 1'b0);
        checkOutput("halt_halted", 4'b0000, 1'b1);
        applyStimulus(4'b1111, 16'h8765, 1'b0);
        checkOutput("halt_release", 4'b0000, 1'b1);
        checkOutput("resume_a", 4'b0001, 1'b0);
        checkOutput("resume_b", 4'b0010, 1'b0);

        checkOutput("drain_pre", 4'b0100, 1'b0);
        applyStimulus(4'b1111, 16'h8765, 1'b1);
        checkOutput("drain_halt", 4'b0000, 1'b0);
        applyStimulus(4'b1111, 16'h8765, 1'b0);
        checkOutput("drain_abort", 4'b0000, 1'b0);
        checkOutput("drain_resume", 4'b1000, 1'b0);

        applyStimulus(4'b0000, 16'h0000, 1'b0);
        checkOutput("idle", 4'b0000, 1'b0);
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        checkOutput("ehalt_run", 4'b0000, 1'b0);
        checkOutput("ehalt_drain", 4'b0000, 1'b0);
        checkOutput("ehalt_halted", 4'b0000, 1'b1);
        applyStimulus(4'b0000, 16'h0000, 1'b0);
        checkOutput("ehalt_release", 4'b0000, 1'b1);

        applyStimulus(4'b1111, 16'hFEDC, 1'b0);
        checkOutput("rst_pre", 4'b0001, 1'b0);
        rst = 1'b1;
        q1.delete();
        checkOutput("rst_hold", 4'b0000, 1'b0);
        rst = 1'b0;
        applyStimulus(4'b1101, 16'hFEDC, 1'b0);
        checkOutput("rst_first", 4'b0001, 1'b0);
        checkOutput("rst_second", 4'b0100, 1'b0);
        applyStimulus(4'b0000, 16'h0000, 1'b0);
        checkOutput("rst_idle", 4'b0000, 1'b0);

        for (int i = 0; i < 16; i++) begin
            bus3.req      = 4'b0010;
            bus3.req_addr = {8'h00, 4'(i), 4'h0};
            @(negedge clk);
            chk("lat3_gnt", 32'(bus3.gnt), 32'(4'b0010));
            chk("lat3_rom_addr", 32'(bus3.rom_addr), 32'(i));
            q3.push_back('{vld: 4'b0010, data: romWord(4'(i)), due: cyc + 3});
            @(posedge clk);
            #1;
        end
        bus3.req      = '0;
        bus3.req_addr = '0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("lat3_tail", 4'b0000, 1'b0);
        end

        chk("queues_drained", 32'(q1.size() + q3.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
Shares one single-port synchronous ROM (rom_case: en, addr in; dout registered) among NREQ requesters. Uses round-robin arbitration and a tag pipeline that routes each ROM word back to its issuer. Has a halt/drain FSM that quiesces ROM traffic so the ROM image can be swapped or checked. Sits between client engines and the rom_case instance.

Parameters:
AW, 4, ROM address width
DW, 16, ROM data width
NREQ, 4, number of requesters (2..8)
ROM_LAT, 1, ROM read latency in cycles from en to dout valid (1..4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req  in  NREQ  per-requester request (valid)
req_addr  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW]
gnt  out  NREQ  one-hot grant (ready); transfer when req[i] && gnt[i]
halt  in  1  stop issuing new ROM reads
halted  out  1  high when halted and no reads in flight
rom_en  out  1  ROM enable
rom_addr  out  AW  ROM address
rom_dout  in  DW  ROM data
rsp_valid  out  NREQ  one-hot response strobe, one cycle
rsp_data  out  DW  response data, valid when any rsp_valid bit set

Behaviour:
- Reset: state=RUN, rr pointer=0, tag pipeline cleared. gnt=0, rsp_valid=0, halted=0, rom_en=0.
- Arbitration is combinational from req, the registered pointer and state.
  - In RUN, gnt = first set req bit searching from pointer upward, wrapping at NREQ.
  - At most one gnt bit is high; gnt=0 when req=0 or state!=RUN.
- rom_en = |gnt. rom_addr = req_addr slice of the winner; rom_addr=0 when no grant.
- Pointer update: on a transfer from requester k, pointer <= (k+1) mod NREQ. Otherwise unchanged.
- Throughput: one transfer per cycle. With req held continuously, consecutive grants rotate.
- Tag pipeline: ROM_LAT stages of {valid, id}; a transfer in cycle N enters stage 1.
  - Cycle N+ROM_LAT: rsp_valid[id]=1 and rsp_data=rom_dout (combinational pass-through).
  - rsp_data=0 when no response is valid.
  - No backpressure on responses; requesters must accept them.
- FSM states:
  - RUN: grants allowed. halt=1 -> DRAIN; no grant is issued in the cycle halt is first seen.
  - DRAIN: no grants. Pipeline empty -> HALTED; halt deasserted first -> RUN.
  - HALTED: halted=1. halt=0 -> RUN next cycle; grants resume from the saved pointer.
- Simultaneous events:
  - halt rising while the pipeline is already empty: RUN -> DRAIN -> HALTED, halted one cycle later.
  - Responses in flight keep completing during DRAIN.
- Reset mid-operation: in-flight responses are dropped (no rsp_valid after reset), pointer returns to 0.
- A requester holding req after a transfer is treated as a new request (valid/ready semantics).

Decomposition:
- Package rom_arb_pkg:
  - state enum {RUN, DRAIN, HALTED} (2-bit)
  - tag struct {logic vld; logic [$clog2(NREQ)-1:0] id}
  - function for rotate-and-priority-pick
- Sub-module rr_pick: combinational round-robin one-hot selector, inputs req and pointer, outputs one-hot plus index.
- Top level holds the pointer, FSM, tag pipeline and the rom_case instance in the bench.

Test Plan:
- Single request: req=4'b0100, addr 4'h9 for one cycle -> gnt=4'b0100 and rom_addr=9 the same cycle; rsp_valid=4'b0100 one cycle later (ROM_LAT=1); rsp_data equals rom_case word 9.
- All four requesting continuously with addrs 1,2,3,4 -> grants 0,1,2,3,0,... each cycle; each rsp_valid id matches its grant; data matches words 1..4.
- Fairness: pointer at 2, req=4'b1011 -> gnt=4'b1000, then 4'b0001, then 4'b0010.
- Halt: stream active, halt=1 -> gnt=0 from that cycle; outstanding responses (ROM_LAT) still delivered; halted=1 once pipeline empty; halt=0 -> grants resume from saved pointer.
- Reset mid-stream: rst pulsed right after a transfer -> no rsp_valid afterward; gnt=0 during reset; first grant after release goes to the lowest req index.
- ROM_LAT=3 build: 16 back-to-back reads from requester 1, addrs 0..15 -> rsp_valid[1] set on 16 consecutive cycles starting 3 cycles after the first grant; data in address order.
